// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges the non-stallable pipeline W-stage write with a
// valid/ready long-latency result stream onto one register-file write port.
// Long results wait in a 2-entry FIFO. A starvation counter freezes the
// pipeline for one cycle to force the FIFO head out.
// Optional build macro: WB_TRACE_EN adds a simulation commit trace.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic [31:0] w_pc,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_addr,
  input  logic [31:0] l_data,
  input  logic [31:0] l_pc,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic [31:0] rf_pc,
  output logic [31:0] pend_mask,
  output logic        stall_w
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // FIFO storage: a valid bit per slot lets a newer pipeline write cancel an
  // older queued result without disturbing the pointers.
  logic [1:0]       vld_q, vld_d;
  logic [1:0][4:0]  addr_q, addr_d;
  logic [1:0][31:0] data_q, data_d;
  logic [1:0][31:0] pc_q, pc_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [3:0]       starve_q, starve_d;

  logic wslot_s;
  logic empty_s;
  logic commit_s;
  logic enq_s;

  assign stall_w  = (starve_q == STARVE_LIM);
  assign l_ready  = (count_q < 2'd2);
  assign wslot_s  = w_we && (w_addr != 5'd0) && !stall_w;
  assign empty_s  = (count_q == 2'd0);
  assign commit_s = !empty_s && !wslot_s;
  // Writes to $0 are handshaken but dropped on the floor.
  assign enq_s    = l_valid && l_ready && (l_addr != 5'd0);

  // Write-port mux: pipeline first, then a still-valid FIFO head, else idle.
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = 5'd0;
    rf_wd = 32'd0;
    rf_pc = 32'd0;
    if (!reset && wslot_s) begin
      rf_we = 1'b1;
      rf_a3 = w_addr;
      rf_wd = w_data;
      rf_pc = w_pc;
    end else if (!reset && commit_s && vld_q[head_q]) begin
      rf_we = 1'b1;
      rf_a3 = addr_q[head_q];
      rf_wd = data_q[head_q];
      rf_pc = pc_q[head_q];
    end else begin
      rf_we = 1'b0;
    end
  end

  // Pending-write mask from registered entries only (valid entries never hold $0).
  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      pend_mask = pend_mask | ({31'd0, vld_q[i]} << addr_q[i]);
    end
  end

  // Next-state: cancel, pop, push and starvation bookkeeping.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int i = 0; i < 2; i++) begin
      vld_d[i] = vld_q[i] & ~(wslot_s && (addr_q[i] == w_addr));
    end
    if (commit_s) begin
      vld_d[head_q] = 1'b0;
      head_d        = ~head_q;
    end else begin
      head_d = head_q;
    end
    if (enq_s) begin
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = l_addr;
      data_d[tail_q] = l_data;
      pc_d[tail_q]   = l_pc;
      tail_d         = ~tail_q;
    end else begin
      tail_d = tail_q;
    end
    count_d = count_q + {1'b0, enq_s} - {1'b0, commit_s};
    if (empty_s || commit_s) begin
      starve_d = 4'd0;
    end else if (wslot_s) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers; reset discards anything queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q    <= 2'b00;
      addr_q   <= 10'd0;
      data_q   <= 64'd0;
      pc_q     <= 64'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      starve_q <= 4'd0;
    end else begin
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

`ifdef WB_TRACE_EN
  // Single commit trace covering both write sources.
  always @(posedge clk) begin
    if (rf_we && !reset) begin
      $display("@%h: $%d <= %h", rf_pc, rf_a3, rf_wd);
    end else begin
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a constant table for the pipeline
// path, hand sequences for queue corner cases and a random run against a
// queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we, l_valid, l_ready, rf_we, stall_w;
  logic [4:0]  w_addr, l_addr, rf_a3;
  logic [31:0] w_data, w_pc, l_data, l_pc, rf_wd, rf_pc, pend_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
    .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_data(l_data), .l_pc(l_pc),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc),
    .pend_mask(pend_mask), .stall_w(stall_w)
  );

  // Reference model: queue of pending long results plus a starvation count.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          valid;
  } ent_t;
  ent_t mq[$];
  int   m_starve;

  logic        e_we, e_ready, e_stall, e_wslot, e_commit;
  logic [4:0]  e_a3;
  logic [31:0] e_wd, e_pc, e_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
  endtask

  task automatic predict();
    e_stall  = (m_starve == STARVE_MAX);
    e_wslot  = w_we && (w_addr != 5'd0) && !e_stall;
    e_commit = (mq.size() != 0) && !e_wslot;
    e_ready  = (mq.size() < 2);
    e_mask   = 32'd0;
    foreach (mq[i]) if (mq[i].valid) e_mask[mq[i].addr] = 1'b1;
    if (e_wslot) begin
      e_we = 1'b1; e_a3 = w_addr; e_wd = w_data; e_pc = w_pc;
    end else if (e_commit && mq[0].valid) begin
      e_we = 1'b1; e_a3 = mq[0].addr; e_wd = mq[0].data; e_pc = mq[0].pc;
    end else begin
      e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; e_pc = 32'd0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".rf_we"}, rf_we, e_we);
    chk({tag, ".rf_a3"}, rf_a3, e_a3);
    chk({tag, ".rf_wd"}, rf_wd, e_wd);
    chk({tag, ".rf_pc"}, rf_pc, e_pc);
    chk({tag, ".l_ready"}, l_ready, e_ready);
    chk({tag, ".pend_mask"}, pend_mask, e_mask);
    chk({tag, ".stall_w"}, stall_w, e_stall);
  endtask

  task automatic advance();
    ent_t e;
    if (e_wslot) foreach (mq[i]) if (mq[i].valid && mq[i].addr == w_addr) mq[i].valid = 1'b0;
    if (mq.size() == 0 || e_commit) m_starve = 0;
    else if (e_wslot) m_starve++;
    if (e_commit) void'(mq.pop_front());
    if (l_valid && e_ready && l_addr != 5'd0) begin
      e.addr = l_addr; e.data = l_data; e.pc = l_pc; e.valid = 1'b1;
      mq.push_back(e);
    end
  endtask

  // Inputs are driven just after a falling edge; check mid-cycle, then clock.
  task automatic pre(input string tag);
    #2;
    predict();
    compare_all(tag);
  endtask

  task automatic post();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    w_we = we; w_addr = wa; w_data = wd; w_pc = 32'h3000 + {27'd0, wa} * 32'd4;
    l_valid = lv; l_addr = la; l_data = ld; l_pc = 32'h8000 + {27'd0, la} * 32'd4;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        exp_we;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tv[5];

  initial begin
    tv[0] = '{1'b1, 5'd5,  32'h0000_1234, 32'h3000, 1'b1, 5'd5,  32'h0000_1234, 32'h3000};
    tv[1] = '{1'b1, 5'd0,  32'h0000_5555, 32'h3004, 1'b0, 5'd0,  32'h0,         32'h0};
    tv[2] = '{1'b0, 5'd7,  32'h0000_0077, 32'h3008, 1'b0, 5'd0,  32'h0,         32'h0};
    tv[3] = '{1'b1, 5'd31, 32'hffff_ffff, 32'h300c, 1'b1, 5'd31, 32'hffff_ffff, 32'h300c};
    tv[4] = '{1'b1, 5'd1,  32'h0,         32'h3010, 1'b1, 5'd1,  32'h0,         32'h3010};

    reset = 1'b1;
    drive(1'b1, 5'd5, 32'h1111, 1'b0, 5'd0, 32'd0);
    model_reset();
    @(negedge clk);
    #2;
    chk("rst.rf_we", rf_we, 1'b0);
    chk("rst.l_ready", l_ready, 1'b1);
    chk("rst.pend_mask", pend_mask, 32'd0);
    chk("rst.stall_w", stall_w, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Pipeline-only vectors with an empty FIFO.
    for (int i = 0; i < 5; i++) begin
      w_we = tv[i].we; w_addr = tv[i].addr; w_data = tv[i].data; w_pc = tv[i].pc;
      pre($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.we", i), rf_we, tv[i].exp_we);
      chk($sformatf("vec%0d.a3", i), rf_a3, tv[i].exp_a3);
      chk($sformatf("vec%0d.wd", i), rf_wd, tv[i].exp_wd);
      chk($sformatf("vec%0d.pc", i), rf_pc, tv[i].exp_pc);
      post();
    end

    // Long result into an idle port.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hdead_beef);
    pre("idle_push"); post();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    pre("idle_commit");
    chk("idle.mask", pend_mask, 32'h0000_0100);
    chk("idle.we", rf_we, 1'b1);
    chk("idle.a3", rf_a3, 5'd8);
    chk("idle.wd", rf_wd, 32'hdead_beef);
    post();
    pre("idle_after");
    chk("idle.mask_clr", pend_mask, 32'd0);
    post();

    // Full FIFO under continuous pipeline writes; forced commit by starvation.
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, 5'd3, 32'h100 + c, 1'b1, (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12,
            32'hA000 + c);
      pre($sformatf("full%0d", c));
      if (c >= 2 && c <= 5) chk("full.l_ready", l_ready, 1'b0);
      if (c == 5) begin
        chk("full.stall", stall_w, 1'b1);
        chk("full.forced_a3", rf_a3, 5'd10);
        chk("full.forced_we", rf_we, 1'b1);
      end
      if (c == 4 || c == 6) chk("full.no_stall", stall_w, 1'b0);
      post();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int c = 0; c < 3; c++) begin pre("drain"); post(); end

    // Newer pipeline write cancels a queued result for the same register.
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h0000_00AA);
    pre("ovw_push"); post();
    drive(1'b1, 5'd9, 32'h0000_00BB, 1'b0, 5'd0, 32'd0);
    pre("ovw_hit");
    chk("ovw.wd", rf_wd, 32'h0000_00BB);
    chk("ovw.mask_before", pend_mask, 32'h0000_0200);
    post();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    pre("ovw_pop");
    chk("ovw.mask_clr", pend_mask, 32'd0);
    chk("ovw.no_write", rf_we, 1'b0);
    post();
    pre("ovw_empty"); post();

    // Simultaneous push and pop at count 1 across pointer wrap.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    pre("sim0"); post();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66);
    pre("sim1"); chk("sim1.a3", rf_a3, 5'd4); chk("sim1.mask", pend_mask, 32'h10); post();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    pre("sim2"); chk("sim2.a3", rf_a3, 5'd6); chk("sim2.mask", pend_mask, 32'h40); post();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    pre("sim3"); chk("sim3.a3", rf_a3, 5'd7); chk("sim3.wd", rf_wd, 32'h77); post();

    // Reset in the middle of a full, starving queue.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 5'd3, 32'h200 + c, 1'b1, (c == 0) ? 5'd13 : 5'd14, 32'hB000 + c);
      pre($sformatf("rq%0d", c)); post();
    end
    pre("rq_stall");
    chk("rq.stall_pre", stall_w, 1'b1);
    reset = 1'b1;
    #1;
    chk("rq.l_ready", l_ready, 1'b1);
    chk("rq.mask", pend_mask, 32'd0);
    chk("rq.rf_we", rf_we, 1'b0);
    chk("rq.stall_w", stall_w, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    pre("rq_after"); post();

    // Random traffic on a small register range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 3) != 0, 5'($urandom % 8), $urandom,
            ($urandom % 2) != 0, 5'($urandom % 8), $urandom);
      pre("rand");
      post();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
